// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
//   Shared encodings for the execute slice:
//     - 6-bit ALU operation codes driven on alu_control_out
//     - ALUOP operation-class codes from the control unit
//     - R-type func field codes (instruction[5:0])
//   Also holds the signed-overflow helpers used by the ALU.
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

  localparam int OP_W = 6;

  // Decoded ALU operation codes
  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_AND  = 6'd2;
  localparam logic [OP_W-1:0] OP_OR   = 6'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 6'd5;
  localparam logic [OP_W-1:0] OP_SLT  = 6'd6;
  localparam logic [OP_W-1:0] OP_SLTU = 6'd7;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd8;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd9;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd10;
  localparam logic [OP_W-1:0] OP_LUI  = 6'd11;

  // ALUOP operation classes
  localparam logic [5:0] ALUOP_RTYPE = 6'd0;
  localparam logic [5:0] ALUOP_ADD   = 6'd1;
  localparam logic [5:0] ALUOP_SUB   = 6'd2;
  localparam logic [5:0] ALUOP_AND   = 6'd3;
  localparam logic [5:0] ALUOP_OR    = 6'd4;
  localparam logic [5:0] ALUOP_XOR   = 6'd5;
  localparam logic [5:0] ALUOP_SLT   = 6'd6;
  localparam logic [5:0] ALUOP_SLTU  = 6'd7;
  localparam logic [5:0] ALUOP_LUI   = 6'd8;

  // R-type func codes
  localparam logic [5:0] FUNC_SLL  = 6'h04;
  localparam logic [5:0] FUNC_SRL  = 6'h06;
  localparam logic [5:0] FUNC_SRA  = 6'h07;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_ADDU = 6'h21;
  localparam logic [5:0] FUNC_SUB  = 6'h22;
  localparam logic [5:0] FUNC_SUBU = 6'h23;
  localparam logic [5:0] FUNC_AND  = 6'h24;
  localparam logic [5:0] FUNC_OR   = 6'h25;
  localparam logic [5:0] FUNC_XOR  = 6'h26;
  localparam logic [5:0] FUNC_NOR  = 6'h27;
  localparam logic [5:0] FUNC_SLT  = 6'h2A;
  localparam logic [5:0] FUNC_SLTU = 6'h2B;

  // Signed overflow of A+B: operands agree in sign, result disagrees.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  // Signed overflow of A-B: operands differ in sign, result differs from A.
  function automatic logic sub_ovf(input logic sign_a, input logic sign_b,
                                   input logic sign_r);
    return (sign_a != sign_b) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
//   ALU-control decode: maps the control unit's ALUOP class (and, for
//   R-type, the func field) to a 6-bit ALU operation code.
//   Ports:
//     aluop_i    in  6  operation class
//     func_i     in  6  instruction[5:0], only consulted when aluop_i==RTYPE
//     op_o       out 6  decoded ALU op (ADD for anything unrecognised)
//     illegal_o  out 1  unknown ALUOP class or unknown R-type func
// ---------------------------------------------------------------------------
module alu_ctrl_decode
  import alu_exec_unit_pkg::*;
(
  input  logic [5:0]      aluop_i,
  input  logic [5:0]      func_i,
  output logic [OP_W-1:0] op_o,
  output logic            illegal_o
);

  // Class/func decode; unrecognised encodings fall back to ADD and flag illegal
  always_comb begin
    op_o      = OP_ADD;
    illegal_o = 1'b0;
    case (aluop_i)
      ALUOP_RTYPE: begin
        case (func_i)
          FUNC_ADD, FUNC_ADDU: op_o = OP_ADD;
          FUNC_SUB, FUNC_SUBU: op_o = OP_SUB;
          FUNC_AND:            op_o = OP_AND;
          FUNC_OR:             op_o = OP_OR;
          FUNC_XOR:            op_o = OP_XOR;
          FUNC_NOR:            op_o = OP_NOR;
          FUNC_SLT:            op_o = OP_SLT;
          FUNC_SLTU:           op_o = OP_SLTU;
          FUNC_SLL:            op_o = OP_SLL;
          FUNC_SRL:            op_o = OP_SRL;
          FUNC_SRA:            op_o = OP_SRA;
          default: begin
            op_o      = OP_ADD;
            illegal_o = 1'b1;
          end
        endcase
      end
      ALUOP_ADD:  op_o = OP_ADD;
      ALUOP_SUB:  op_o = OP_SUB;
      ALUOP_AND:  op_o = OP_AND;
      ALUOP_OR:   op_o = OP_OR;
      ALUOP_XOR:  op_o = OP_XOR;
      ALUOP_SLT:  op_o = OP_SLT;
      ALUOP_SLTU: op_o = OP_SLTU;
      ALUOP_LUI:  op_o = OP_LUI;
      default: begin
        op_o      = OP_ADD;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Single-cycle execute slice: ALU-control decode, WIDTH-bit ALU and PC
//   incrementer. All primary outputs are combinational; result/zero are
//   also captured in a status register for debug and branch timing.
//   Ports:
//     clk, reset       clock; synchronous active-high reset of the
//                      registered copies only
//     ALUOP, func      operation class and R-type func field
//     read_data1       operand A (also supplies shift amount [4:0])
//     read_data2       operand B (shift value, LUI immediate)
//     pc               current program counter
//     alu_control_out  decoded op code (comb)
//     ALU_result, zero, overflow, illegal_op   ALU outputs (comb)
//     pc_end           pc + PC_STEP, wrapping (comb)
//     result_q, zero_q registered ALU_result / zero
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PC_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       ALUOP,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] read_data1,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] pc,
  output logic [5:0]       alu_control_out,
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal_op,
  output logic [WIDTH-1:0] pc_end,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(PC_STEP);

  logic [OP_W-1:0]  op_s;
  logic             illegal_s;
  logic [WIDTH-1:0] alu_result_s;
  logic             overflow_s;
  logic             zero_s;
  logic [4:0]       shamt_s;
  logic             unused_shamt_hi_s;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;

  alu_ctrl_decode u_decode (
    .aluop_i   (ALUOP),
    .func_i    (func),
    .op_o      (op_s),
    .illegal_o (illegal_s)
  );

  // Shift amount is only the low five bits of operand A; upper bits are ignored.
  assign shamt_s           = read_data1[4:0];
  assign unused_shamt_hi_s = |read_data1[WIDTH-1:5];

  // ALU datapath; overflow is only meaningful for ADD/SUB
  always_comb begin
    alu_result_s = '0;
    overflow_s   = 1'b0;
    case (op_s)
      OP_ADD: begin
        alu_result_s = read_data1 + read_data2;
        overflow_s   = add_ovf(read_data1[WIDTH-1], read_data2[WIDTH-1],
                               alu_result_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result_s = read_data1 - read_data2;
        overflow_s   = sub_ovf(read_data1[WIDTH-1], read_data2[WIDTH-1],
                               alu_result_s[WIDTH-1]);
      end
      OP_AND:  alu_result_s = read_data1 & read_data2;
      OP_OR:   alu_result_s = read_data1 | read_data2;
      OP_XOR:  alu_result_s = read_data1 ^ read_data2;
      OP_NOR:  alu_result_s = ~(read_data1 | read_data2);
      OP_SLT:  alu_result_s = {{(WIDTH-1){1'b0}},
                               ($signed(read_data1) < $signed(read_data2))};
      OP_SLTU: alu_result_s = {{(WIDTH-1){1'b0}}, (read_data1 < read_data2)};
      OP_SLL:  alu_result_s = read_data2 << shamt_s;
      OP_SRL:  alu_result_s = read_data2 >> shamt_s;
      OP_SRA:  alu_result_s = $unsigned($signed(read_data2) >>> shamt_s);
      OP_LUI:  alu_result_s = {read_data2[15:0], {(WIDTH-16){1'b0}}};
      default: begin
        alu_result_s = '0;
        overflow_s   = 1'b0;
      end
    endcase
  end

  assign zero_s          = (alu_result_s == '0);
  assign alu_control_out = op_s;
  assign ALU_result      = alu_result_s;
  assign zero            = zero_s;
  assign overflow        = overflow_s;
  assign illegal_op      = illegal_s;
  assign pc_end          = pc + PC_INC;

  assign result_d = alu_result_s;
  assign zero_d   = zero_s;

  // Status register: reset has priority over the per-cycle capture
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Directed vectors with hand-computed expectations for alu_exec_unit.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  ALUOP;
  logic [5:0]  func;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] pc;
  logic [5:0]  alu_control_out;
  logic [31:0] ALU_result;
  logic        zero;
  logic        overflow;
  logic        illegal_op;
  logic [31:0] pc_end;
  logic [31:0] result_q;
  logic        zero_q;

  int vec_cnt;
  int miss_cnt;

  alu_exec_unit #(.WIDTH(32), .PC_STEP(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .ALUOP           (ALUOP),
    .func            (func),
    .read_data1      (read_data1),
    .read_data2      (read_data2),
    .pc              (pc),
    .alu_control_out (alu_control_out),
    .ALU_result      (ALU_result),
    .zero            (zero),
    .overflow        (overflow),
    .illegal_op      (illegal_op),
    .pc_end          (pc_end),
    .result_q        (result_q),
    .zero_q          (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation, check comb outputs, then the registered copies.
  task automatic run_vec(input string tag, input logic [5:0] aluop,
                         input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] e_op,
                         input logic [31:0] e_res, input logic e_zero,
                         input logic e_ovf, input logic e_ill);
    @(negedge clk);
    ALUOP      = aluop;
    func       = fn;
    read_data1 = a;
    read_data2 = b;
    #1;
    chk({tag, ".op"},   {26'd0, alu_control_out}, {26'd0, e_op});
    chk({tag, ".res"},  ALU_result, e_res);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, e_zero});
    chk({tag, ".ovf"},  {31'd0, overflow}, {31'd0, e_ovf});
    chk({tag, ".ill"},  {31'd0, illegal_op}, {31'd0, e_ill});
    @(posedge clk);
    #1;
    chk({tag, ".res_q"},  result_q, e_res);
    chk({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, e_zero});
  endtask

  task automatic run_pc(input string tag, input logic [31:0] p,
                        input logic [31:0] e);
    @(negedge clk);
    pc = p;
    #1;
    chk(tag, pc_end, e);
  endtask

  initial begin
    vec_cnt    = 0;
    miss_cnt   = 0;
    reset      = 1'b1;
    ALUOP      = 6'd0;
    func       = 6'h20;
    read_data1 = 32'd5;
    read_data2 = 32'd7;
    pc         = 32'd0;

    // Reset state: registered copies cleared even though ALU_result=12
    repeat (2) @(posedge clk);
    #1;
    chk("rst.res_q",  result_q, 32'd0);
    chk("rst.zero_q", {31'd0, zero_q}, 32'd0);
    chk("rst.comb",   ALU_result, 32'd12);
    @(negedge clk);
    reset = 1'b0;

    //       tag      ALUOP  func   A             B             op      result        z     ov    ill
    run_vec("radd",   6'd0, 6'h20, 32'd5,        32'd7,        6'd0,  32'd12,       1'b0, 1'b0, 1'b0);
    run_vec("beq",    6'd2, 6'h00, 32'h1234,     32'h1234,     6'd1,  32'd0,        1'b1, 1'b0, 1'b0);
    run_vec("addov",  6'd1, 6'h00, 32'h7FFFFFFF, 32'd1,        6'd0,  32'h80000000, 1'b0, 1'b1, 1'b0);
    run_vec("subov",  6'd2, 6'h00, 32'h80000000, 32'd1,        6'd1,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_vec("slt",    6'd6, 6'h00, 32'hFFFFFFFF, 32'd1,        6'd6,  32'd1,        1'b0, 1'b0, 1'b0);
    run_vec("sltu",   6'd7, 6'h00, 32'hFFFFFFFF, 32'd1,        6'd7,  32'd0,        1'b1, 1'b0, 1'b0);
    run_vec("sra",    6'd0, 6'h07, 32'd4,        32'h80000000, 6'd10, 32'hF8000000, 1'b0, 1'b0, 1'b0);
    run_vec("srl",    6'd0, 6'h06, 32'd31,       32'h80000000, 6'd9,  32'd1,        1'b0, 1'b0, 1'b0);
    run_vec("sll",    6'd0, 6'h04, 32'h24,       32'd1,        6'd8,  32'h10,       1'b0, 1'b0, 1'b0);
    run_vec("lui",    6'd8, 6'h00, 32'd0,        32'h0000ABCD, 6'd11, 32'hABCD0000, 1'b0, 1'b0, 1'b0);
    run_vec("and",    6'd3, 6'h00, 32'hF0F0,     32'hFF00,     6'd2,  32'hF000,     1'b0, 1'b0, 1'b0);
    run_vec("or",     6'd4, 6'h00, 32'hF0F0,     32'h0F0F,     6'd3,  32'hFFFF,     1'b0, 1'b0, 1'b0);
    run_vec("xor",    6'd5, 6'h00, 32'hFFFF,     32'h0F0F,     6'd4,  32'hF0F0,     1'b0, 1'b0, 1'b0);
    run_vec("nor",    6'd0, 6'h27, 32'd0,        32'd0,        6'd5,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_vec("addu",   6'd0, 6'h21, 32'h7FFFFFFF, 32'h7FFFFFFF, 6'd0,  32'hFFFFFFFE, 1'b0, 1'b1, 1'b0);
    run_vec("subu",   6'd0, 6'h23, 32'd3,        32'd5,        6'd1,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    run_vec("rslt",   6'd0, 6'h2A, 32'd1,        32'hFFFFFFFF, 6'd6,  32'd0,        1'b1, 1'b0, 1'b0);
    run_vec("rsltu",  6'd0, 6'h2B, 32'd1,        32'hFFFFFFFF, 6'd7,  32'd1,        1'b0, 1'b0, 1'b0);
    run_vec("badfn",  6'd0, 6'h3F, 32'd1,        32'd2,        6'd0,  32'd3,        1'b0, 1'b0, 1'b1);
    run_vec("badop",  6'd9, 6'h20, 32'd0,        32'd0,        6'd0,  32'd0,        1'b1, 1'b0, 1'b1);
    run_vec("fnign",  6'd1, 6'h3F, 32'd1,        32'd1,        6'd0,  32'd2,        1'b0, 1'b0, 1'b0);

    run_pc("pc0",    32'd0,        32'd4);
    run_pc("pcwrap", 32'hFFFFFFFC, 32'd0);
    run_pc("pcmid",  32'h00000400, 32'h00000404);

    // Mid-operation reset: nonzero result_q cleared, comb result untouched
    run_vec("prerst", 6'd1, 6'h00, 32'd10, 32'd20, 6'd0, 32'd30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.res_q", result_q, 32'd0);
    chk("midrst.comb",  ALU_result, 32'd30);
    @(negedge clk);
    reset = 1'b0;

    // zero_q set, then cleared by reset while comb zero stays high
    run_vec("prerst2", 6'd2, 6'h00, 32'h55, 32'h55, 6'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.zero_q", {31'd0, zero_q}, 32'd0);
    chk("midrst.zero",   {31'd0, zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst.zero_q", {31'd0, zero_q}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
